fifo_burst_wr: RTL and testbench
================================

# fifo_burst_wr

Write-side controller for the FIFO loopback test path. It waits until the FIFO reports almost-empty, waits a fixed settle period for the FIFO status flags to catch up, then writes an incrementing 8-bit pattern on every cycle until the FIFO reports almost-full or full. It pairs with the existing read-side controller, which drains the FIFO when it fills. The block also counts completed bursts and flags any write attempted into a full FIFO.

## Interface
Parameters:
- DATA_W, 8, width of the write data pattern.
- SETTLE_CYC, 10, settle delay in cycles between detecting almost-empty and starting writes.

Ports:
- clk  in  1  system clock; single clock domain for all block logic.
- rst  in  1  synchronous, active-high reset.
- almost_empty  in  1  FIFO almost-empty flag; generated in the FIFO read domain, so it is treated as asynchronous.
- almost_full  in  1  FIFO almost-full flag; in the clk domain.
- full  in  1  FIFO full flag; in the clk domain.
- fifo_wr_en  out  1  FIFO write enable; registered.
- fifo_din  out  DATA_W  FIFO write data; registered.
- burst_cnt  out  16  number of completed non-empty bursts; wraps from 0xFFFF to 0.
- busy  out  1  high in SETTLE and WRITE states.
- ovf_err  out  1  sticky flag: a write was attempted while the FIFO was full.

## Operation
- **almost_empty synchroniser:** almost_empty passes through a 2-flop synchroniser (ae_d0, ae_syn) before any use. almost_full and full are used directly.
- **State machine states:** IDLE, SETTLE, WRITE. Any unused encoding returns to IDLE.
- **IDLE:**
  - fifo_wr_en = 0.
  - If ae_syn = 1, go to SETTLE with dly_cnt = 0.
- **SETTLE:**
  - dly_cnt increments each cycle.
  - When dly_cnt == SETTLE_CYC, clear dly_cnt and go to WRITE.
  - The block therefore spends SETTLE_CYC+1 cycles in SETTLE.
- **WRITE:** evaluated at each edge.
  - If almost_full or full is high: fifo_wr_en <= 0 and state <= IDLE. burst_cnt increments only if at least one write occurred in this burst, tracked by the wrote flag, which is cleared on entry to SETTLE.
  - Otherwise: fifo_wr_en <= 1.
- **Data pattern:**
  - On every edge where fifo_wr_en = 1, fifo_din <= fifo_din + 1, modulo 2^DATA_W.
  - The pattern continues across bursts; it is not reset per burst.
- **ovf_err:** set on any edge where fifo_wr_en = 1 and full = 1. It is cleared only by rst.
- **busy:** combinational decode of the state, (state != IDLE).

## Timing
- **Reset values:** fifo_wr_en = 0, fifo_din = 0, burst_cnt = 0, ovf_err = 0, busy = 0. Internally: state = IDLE, dly_cnt = 0, ae_d0/ae_syn = 0, wrote = 0.
- **Reset mid-operation:** rst wins over all other logic on the same edge. Mid-burst reset drops fifo_wr_en the following cycle and restarts fifo_din at 0.
- **Start latency:** almost_empty rising at edge N gives:
  - ae_syn high after edge N+2;
  - SETTLE entered at edge N+3;
  - WRITE entered at edge N+3+SETTLE_CYC+1;
  - first fifo_wr_en = 1 one edge later, i.e. at edge N+SETTLE_CYC+5 (N+15 with default parameters).
- **Stop latency:** fifo_wr_en is registered, so after almost_full rises exactly one further write occurs. almost_full must assert at least 1 entry before full; this is a FIFO configuration requirement.
- **Data/enable alignment:** the word written on a cycle is the fifo_din value present on that same cycle with fifo_wr_en = 1. Consecutive writes carry consecutive values.
- **Zero-length burst:** almost_full already high when WRITE is entered gives return to IDLE, no write, and no burst_cnt increment.
- **Simultaneous almost_full and full:** same handling as almost_full alone. If fifo_wr_en is already 1 on that edge, ovf_err sets.
- **ae_syn still high on return to IDLE:** a new SETTLE begins immediately. This is legal.
- **ae_syn deasserting during SETTLE or WRITE:** ignored.

## Test plan
All scenarios use SETTLE_CYC = 10.

- **Reset:** hold rst 3 cycles with almost_empty = 1, then release → all outputs 0 during reset; first fifo_wr_en = 1 exactly 15 cycles after the release edge.
- **Single burst:** FIFO model with almost_full at 14 entries → writes 0x00..0x0E (15 words, one extra after almost_full); fifo_wr_en low on the next cycle; burst_cnt = 1; ovf_err = 0.
- **Second burst and wrap:** preload fifo_din to 0xFE via earlier bursts, then run one burst of 4 writes → data sequence 0xFE, 0xFF, 0x00, 0x01; burst_cnt increments by 1.
- **Overflow:** force full = 1 for one cycle while fifo_wr_en = 1 → ovf_err = 1 from the next cycle and stays 1 after full drops, until rst.
- **Zero-length burst:** hold almost_full = 1 throughout SETTLE → no fifo_wr_en pulse; burst_cnt unchanged; busy returns to 0.
- **Mid-burst reset:** assert rst during the 5th write → fifo_wr_en = 0 and fifo_din = 0 on the next cycle; the burst is not counted.

Source files
------------

// File: rtl/fifo_burst_wr.sv
// Write-side burst controller: after almost-empty and a settle delay, writes an incrementing pattern until almost-full/full.
// Latency: first write SETTLE_CYC+5 edges after almost_empty rises; one extra write lands after almost_full rises.
// Backpressure: almost_full or full ends the burst; a write issued while full sets the sticky ovf_err flag.
module fifo_burst_wr #(
  parameter int DATA_W     = 8,
  parameter int SETTLE_CYC = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              almost_empty,
  input  logic              almost_full,
  input  logic              full,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_din,
  output logic [15:0]       burst_cnt,
  output logic              busy,
  output logic              ovf_err
);

  // Sized so the counter can hold SETTLE_CYC even when it is 0.
  localparam int CNT_W = $clog2(SETTLE_CYC + 2);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_WRITE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    dly_cnt_q, dly_cnt_d;
  logic                wrote_q, wrote_d;
  logic                wr_en_q, wr_en_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [15:0]         burst_q, burst_d;
  logic                ovf_q, ovf_d;
  logic                ae_d0_q, ae_syn_q;

  // Two-flop synchroniser: almost_empty comes from the FIFO read domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      ae_d0_q  <= 1'b0;
      ae_syn_q <= 1'b0;
    end else begin
      ae_d0_q  <= almost_empty;
      ae_syn_q <= ae_d0_q;
    end
  end

  // Next-state logic: FSM, settle counter, burst bookkeeping, data pattern and overflow flag.
  always_comb begin
    state_d   = state_q;
    dly_cnt_d = dly_cnt_q;
    wrote_d   = wrote_q;
    wr_en_d   = 1'b0;
    burst_d   = burst_q;
    // The word on fifo_din is consumed whenever wr_en is high, so advance after every write.
    din_d     = wr_en_q ? din_q + 1'b1 : din_q;
    ovf_d     = ovf_q | (wr_en_q & full);

    unique case (state_q)
      ST_IDLE: begin
        if (ae_syn_q) begin
          state_d   = ST_SETTLE;
          dly_cnt_d = '0;
          wrote_d   = 1'b0;
        end
      end
      ST_SETTLE: begin
        // Gives the FIFO status flags time to reflect the drained state.
        if (dly_cnt_q == CNT_W'(SETTLE_CYC)) begin
          dly_cnt_d = '0;
          state_d   = ST_WRITE;
        end else begin
          dly_cnt_d = dly_cnt_q + 1'b1;
        end
      end
      ST_WRITE: begin
        if (almost_full || full) begin
          state_d = ST_IDLE;
          // Bursts that never issued a write are not counted.
          if (wrote_q) begin
            burst_d = burst_q + 16'd1;
          end
        end else begin
          wr_en_d = 1'b1;
          wrote_d = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        dly_cnt_d = '0;
      end
    endcase
  end

  // State and output registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      dly_cnt_q <= '0;
      wrote_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      din_q     <= '0;
      burst_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dly_cnt_q <= dly_cnt_d;
      wrote_q   <= wrote_d;
      wr_en_q   <= wr_en_d;
      din_q     <= din_d;
      burst_q   <= burst_d;
      ovf_q     <= ovf_d;
    end
  end

  // Output decode.
  always_comb begin
    fifo_wr_en = wr_en_q;
    fifo_din   = din_q;
    burst_cnt  = burst_q;
    ovf_err    = ovf_q;
    busy       = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_fifo_burst_wr.sv
// Bench for fifo_burst_wr: a FIFO occupancy model drives the flags, a scoreboard checks the written pattern.
// Burst lengths are predicted arithmetically from occupancy and the almost-full threshold.
// Randomised burst sizes walk the data pattern up to its wrap point before the directed corner cases.
module tb_fifo_burst_wr;

  logic        clk = 1'b0;
  logic        rst;
  logic        almost_empty;
  logic        almost_full;
  logic        full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_din;
  logic [15:0] burst_cnt;
  logic        busy;
  logic        ovf_err;

  int          total = 0;
  int          bad   = 0;
  int          occ;
  int          af_thr;
  int          full_thr;
  bit          force_full;
  logic [7:0]  exp_din;
  int          exp_bursts;
  bit          exp_ovf;
  int          nlog;
  logic [7:0]  wlog[$];
  logic [7:0]  wrap_exp [4];

  fifo_burst_wr #(.DATA_W(8), .SETTLE_CYC(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .full         (full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_din     (fifo_din),
    .burst_cnt    (burst_cnt),
    .busy         (busy),
    .ovf_err      (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // FIFO flags follow the modelled occupancy.
  task automatic upd();
    almost_full = (occ >= af_thr);
    full        = force_full || (occ >= full_thr);
  endtask

  // One clock: capture the write presented before the edge, then refresh flags.
  task automatic tick();
    logic       w;
    logic [7:0] d;
    w = fifo_wr_en;
    d = fifo_din;
    @(posedge clk);
    #1;
    if (w === 1'b1) begin
      chk("wr_data", d, exp_din);
      exp_din = exp_din + 8'd1;
      occ++;
      nlog++;
      wlog.push_back(d);
    end
    upd();
  endtask

  // Pulse almost_empty and check the start latency: first write after the 15th edge.
  task automatic launch(input int o, input int t, input int expn);
    occ      = o;
    af_thr   = t;
    full_thr = t + 2;
    upd();
    almost_empty = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 1) almost_empty = 1'b0;
      if (k == 2) chk("busy_pre", busy, 0);
      if (k == 3) chk("busy_settle", busy, 1);
      if (k == 14) chk("wr_en_early", fifo_wr_en, 0);
    end
    chk("wr_en_first", fifo_wr_en, (expn > 0));
  endtask

  // Run the burst out and check length, return to idle and counters.
  task automatic drain(input int expn);
    int start;
    int guard;
    start = nlog;
    guard = 0;
    while (fifo_wr_en === 1'b1 && guard < 400) begin
      tick();
      guard++;
    end
    chk("wr_en_stop", fifo_wr_en, 0);
    chk("burst_len", nlog - start, expn);
    chk("busy_end", busy, 0);
    exp_bursts++;
    chk("burst_cnt", burst_cnt, exp_bursts);
    chk("ovf", ovf_err, exp_ovf);
  endtask

  initial begin
    int n;
    int o;
    int rem;
    int wsz;
    int b;

    wrap_exp[0] = 8'hFE;
    wrap_exp[1] = 8'hFF;
    wrap_exp[2] = 8'h00;
    wrap_exp[3] = 8'h01;
    rst = 1'b1;
    almost_empty = 1'b1;
    almost_full = 1'b0;
    full = 1'b0;
    force_full = 1'b0;
    occ = 0;
    af_thr = 14;
    full_thr = 16;
    exp_din = 8'd0;
    exp_bursts = 0;
    exp_ovf = 1'b0;
    nlog = 0;

    // Reset held with almost_empty high: everything stays quiet.
    repeat (3) begin
      tick();
      chk("rst_wr_en", fifo_wr_en, 0);
      chk("rst_din", fifo_din, 0);
      chk("rst_burst", burst_cnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ovf", ovf_err, 0);
    end

    // Release: almost_empty already high, so the burst starts 15 edges later; 15 words 0x00..0x0E.
    rst = 1'b0;
    launch(0, 14, 15);
    drain(15);

    // Random bursts carrying the pattern up to 0xFE.
    while (nlog < 254) begin
      rem = 254 - nlog;
      n = $urandom_range(5, 40);
      if (n > rem || rem - n < 5) n = rem;
      o = $urandom_range(0, 3);
      launch(o, o + n - 1, n);
      drain(n);
      repeat ($urandom_range(0, 3)) tick();
    end
    chk("din_pre_wrap", fifo_din, 8'hFE);

    // Four-word burst across the 8-bit wrap.
    wsz = wlog.size();
    launch(0, 3, 4);
    drain(4);
    for (int i = 0; i < 4; i++) chk("wrap_word", wlog[wsz + i], wrap_exp[i]);

    // Zero-length burst: almost_full high throughout.
    b = exp_bursts;
    launch($urandom_range(14, 20), 14, 0);
    chk("zl_busy", busy, 0);
    repeat (3) begin
      tick();
      chk("zl_wr_en", fifo_wr_en, 0);
    end
    chk("zl_burst", burst_cnt, b);

    // Overflow: full for one edge while a write is in flight.
    launch(0, 20, 21);
    tick();
    tick();
    force_full = 1'b1;
    upd();
    tick();
    force_full = 1'b0;
    upd();
    exp_ovf = 1'b1;
    exp_bursts++;
    chk("ovf_set", ovf_err, 1);
    chk("ovf_wr_en", fifo_wr_en, 0);
    chk("ovf_busy", busy, 0);
    repeat (3) tick();
    chk("ovf_sticky", ovf_err, 1);
    chk("ovf_burst", burst_cnt, exp_bursts);

    // Reset during the 5th write: everything clears, burst not counted.
    launch(0, 20, 21);
    repeat (4) tick();
    chk("mr_wr_en_pre", fifo_wr_en, 1);
    rst = 1'b1;
    tick();
    chk("mr_wr_en", fifo_wr_en, 0);
    chk("mr_din", fifo_din, 0);
    chk("mr_burst", burst_cnt, 0);
    chk("mr_ovf", ovf_err, 0);
    chk("mr_busy", busy, 0);
    rst = 1'b0;
    exp_din = 8'd0;
    exp_bursts = 0;
    exp_ovf = 1'b0;

    // Pattern restarts from zero after reset.
    launch(0, 2, 3);
    drain(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
